matmul_tile_sequencer: RTL and testbench
========================================

# matmul_tile_sequencer

Tiles a large matrix multiply (M×K · K×N) into a sequence of SYSTOLIC_ARRAY_DIM-square output-tile commands. It sits directly upstream of the systolic-array core and drives that core's `cmd_matmul` / `resp_matmul` channels. It accepts one host command, issues one core command per output tile with incrementally computed addresses, waits for each tile's response, then returns a single host response. One core command is in flight at a time.

## Interface
Parameters:
- SYSTOLIC_ARRAY_DIM, 8, array edge length, in elements.
- DATA_WIDTH_BITS, 16, element width; must be a multiple of 8.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock.
- areset  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in/out  1  host command handshake.
- cmd_row_tiles  in  16  M / DIM.
- cmd_col_tiles  in  16  N / DIM.
- cmd_inner_dimension  in  20  K, in elements.
- cmd_act_addr, cmd_wgt_addr, cmd_out_addr  in  64  base byte addresses.
- resp_valid / resp_ready  out/in  1  host completion handshake.
- resp_tiles_done  out  32  number of tiles completed for the last command.
- sa_cmd_valid / sa_cmd_ready  out/in  1  core command handshake.
- sa_cmd_inner_dimension  out  20  K, forwarded to the core.
- sa_cmd_act_addr, sa_cmd_wgt_addr, sa_cmd_out_addr  out  64  per-tile addresses.
- sa_resp_valid / sa_resp_ready  in/out  1  core completion handshake.

## Operation
- Memory layout:
  - Activations are row-tile-major; row tile i starts at act_addr + i·P.
  - Weights are col-tile-major; col tile j starts at wgt_addr + j·P.
  - Output tile (i,j) starts at out_addr + (i·col_tiles + j)·Q.
  - P = DIM·(DATA_WIDTH_BITS/8)·K, computed once at accept and held in a 64-bit register.
  - Q = DIM·DIM·(DATA_WIDTH_BITS/8), a constant.
- Iteration order: j is the inner loop, i the outer loop.
- Address update rules (adders only, no multipliers beyond P at accept):
  - At j wrap, wgt_ptr reloads to the base.
  - out_ptr always advances by Q.
- States:
  - IDLE: cmd_ready=1. On fire, latch all fields, set i=j=0, pointers to bases, tiles_done=0.
    - If row_tiles, col_tiles or K is 0, go to RESP.
    - Otherwise go to ISSUE.
  - ISSUE: sa_cmd_valid=1 with stable fields. On sa_cmd_ready, go to WAIT.
  - WAIT: sa_resp_ready=1. On sa_resp_valid:
    - tiles_done++.
    - If (i,j) is the last tile, go to RESP.
    - Otherwise advance the pointers and go to ISSUE.
  - RESP: resp_valid=1. On resp_ready, go to IDLE.
- resp_tiles_done = tiles_done register. It is held until the next accept and equals row_tiles·col_tiles on normal completion.
- A host command arriving outside IDLE is back-pressured, never dropped.
- An sa_resp_valid arriving outside WAIT is ignored (sa_resp_ready=0).

## Timing
- Reset values: state=IDLE, cmd_ready=1 (combinational from state), sa_cmd_valid=0, sa_resp_ready=0, resp_valid=0, resp_tiles_done=0, all address outputs 0.
- Reset mid-operation abandons the in-flight tile with no further core commands. The core must be reset on the same edge.
- Cycle-level latencies:
  - cmd fire at cycle N: sa_cmd_valid high at N+1.
  - sa_resp fire at T (not last): next sa_cmd_valid at T+1, with new addresses already valid.
  - Last sa_resp fire at T: resp_valid at T+1.
  - Degenerate command fired at N: resp_valid at N+1 with tiles_done=0.
- Handshakes:
  - valid never depends combinationally on ready.
  - sa_cmd_* fields are held constant while sa_cmd_valid && !sa_cmd_ready.
- Width rules:
  - All address arithmetic wraps modulo 2^64.
  - Tile counters are 16 bits.
  - tiles_done is 32 bits and does not saturate (max 65535² fits).

## Structure
- Shared package:
  - State enum (IDLE, ISSUE, WAIT, RESP).
  - Function for element bytes (DATA_WIDTH_BITS/8).
  - Tile-bytes constant Q.
- Single module, with no sub-module required. The (i,j) nested counter may be factored as `tile_index_counter` (with wrap and last flags) if reused by the output writer.

## Test plan
- 1×1 tiles, K=8, DIM=8, 16-bit: exactly one sa_cmd with act=act_addr, wgt=wgt_addr, out=out_addr, inner=8; resp_tiles_done=1.
- 2×3 tiles, K=4, bases 0x1000/0x2000/0x3000: six sa_cmds in order (0,0)…(1,2).
  - act steps by 64 per row.
  - wgt cycles 0x2000/0x2040/0x2080.
  - out steps by 128.
  - tiles_done=6.
- cmd_col_tiles=0: no sa_cmd issued; resp_valid one cycle after accept; tiles_done=0.
- sa_cmd_ready held low 5 cycles, plus random sa_resp latency: sa_cmd fields stable throughout; no second sa_cmd before the sa_resp fire.
- resp_ready held low 10 cycles while a new cmd_valid is asserted: cmd_ready stays 0 until the resp fire; the next command is accepted the following cycle.
- areset pulsed during WAIT: next cycle state is IDLE, all outputs at reset values; a subsequent 1×1 command completes normally.

Source files
------------

// File: rtl/matmul_tile_sequencer_pkg.sv
// matmul_tile_sequencer_pkg: shared state encoding and tile size helpers
package matmul_tile_sequencer_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int unsigned DEF_DIM             = 8;
  localparam int unsigned DEF_DATA_WIDTH_BITS = 16;

  function automatic int unsigned elem_bytes(input int unsigned data_width_bits);
    return data_width_bits / 8;
  endfunction

  function automatic logic [63:0] tile_bytes(input int unsigned dim, input int unsigned data_width_bits);
    return 64'(dim) * 64'(dim) * 64'(elem_bytes(data_width_bits));
  endfunction

  localparam logic [63:0] TILE_BYTES = tile_bytes(DEF_DIM, DEF_DATA_WIDTH_BITS);

endpackage

// File: rtl/matmul_tile_sequencer_tile_index_counter.sv
// matmul_tile_sequencer_tile_index_counter: nested (row, col) tile walker with col-wrap and last-tile flags
module matmul_tile_sequencer_tile_index_counter (
  input  logic        clock,
  input  logic        areset,
  input  logic        clear_i,
  input  logic        advance_i,
  input  logic [15:0] row_tiles_i,
  input  logic [15:0] col_tiles_i,
  output logic        col_wrap_o,
  output logic        last_o
);

  logic [15:0] row_q, row_d, col_q, col_d;

  assign col_wrap_o = col_q == col_tiles_i - 16'd1;
  assign last_o     = col_wrap_o && row_q == row_tiles_i - 16'd1;

  // col is the inner loop; row steps only when col wraps
  always_comb begin
    row_d = clear_i ? '0 : advance_i && col_wrap_o ? row_q + 16'd1 : row_q;
    col_d = clear_i || (advance_i && col_wrap_o) ? '0 : advance_i ? col_q + 16'd1 : col_q;
  end

  // index registers
  always_ff @(posedge clock) begin
    if (areset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: splits an M x K . K x N matmul into one core command per output tile
module matmul_tile_sequencer
  import matmul_tile_sequencer_pkg::*;
#(
  parameter int unsigned SYSTOLIC_ARRAY_DIM = DEF_DIM,
  parameter int unsigned DATA_WIDTH_BITS    = DEF_DATA_WIDTH_BITS
) (
  input  logic        clock,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_row_tiles,
  input  logic [15:0] cmd_col_tiles,
  input  logic [19:0] cmd_inner_dimension,
  input  logic [63:0] cmd_act_addr,
  input  logic [63:0] cmd_wgt_addr,
  input  logic [63:0] cmd_out_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_tiles_done,
  output logic        sa_cmd_valid,
  input  logic        sa_cmd_ready,
  output logic [19:0] sa_cmd_inner_dimension,
  output logic [63:0] sa_cmd_act_addr,
  output logic [63:0] sa_cmd_wgt_addr,
  output logic [63:0] sa_cmd_out_addr,
  input  logic        sa_resp_valid,
  output logic        sa_resp_ready
);

  localparam logic [63:0] Q         = tile_bytes(SYSTOLIC_ARRAY_DIM, DATA_WIDTH_BITS);
  localparam logic [63:0] ROW_BYTES = 64'(SYSTOLIC_ARRAY_DIM) * 64'(elem_bytes(DATA_WIDTH_BITS));

  state_e      state_q, state_d;
  logic [15:0] rows_q, rows_d, cols_q, cols_d;
  logic [19:0] inner_q, inner_d;
  logic [63:0] p_q, p_d, wgt_base_q, wgt_base_d;
  logic [63:0] act_q, act_d, wgt_q, wgt_d, out_q, out_d;
  logic [31:0] done_q, done_d;
  logic        clear, advance, col_wrap, tile_last;

  assign resp_tiles_done        = done_q;
  assign sa_cmd_inner_dimension = inner_q;
  assign sa_cmd_act_addr        = act_q;
  assign sa_cmd_wgt_addr        = wgt_q;
  assign sa_cmd_out_addr        = out_q;

  matmul_tile_sequencer_tile_index_counter u_idx (
    .clock       (clock),
    .areset      (areset),
    .clear_i     (clear),
    .advance_i   (advance),
    .row_tiles_i (rows_q),
    .col_tiles_i (cols_q),
    .col_wrap_o  (col_wrap),
    .last_o      (tile_last)
  );

  // next state, handshake outputs and incremental pointer updates
  always_comb begin
    state_d       = state_q;
    rows_d        = rows_q;
    cols_d        = cols_q;
    inner_d       = inner_q;
    p_d           = p_q;
    wgt_base_d    = wgt_base_q;
    act_d         = act_q;
    wgt_d         = wgt_q;
    out_d         = out_q;
    done_d        = done_q;
    cmd_ready     = 1'b0;
    sa_cmd_valid  = 1'b0;
    sa_resp_ready = 1'b0;
    resp_valid    = 1'b0;
    clear         = 1'b0;
    advance       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rows_d     = cmd_row_tiles;
          cols_d     = cmd_col_tiles;
          inner_d    = cmd_inner_dimension;
          p_d        = ROW_BYTES * 64'(cmd_inner_dimension);
          wgt_base_d = cmd_wgt_addr;
          act_d      = cmd_act_addr;
          wgt_d      = cmd_wgt_addr;
          out_d      = cmd_out_addr;
          done_d     = '0;
          clear      = 1'b1;
          state_d    = cmd_row_tiles == '0 || cmd_col_tiles == '0 || cmd_inner_dimension == '0 ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        sa_cmd_valid = 1'b1;
        if (sa_cmd_ready) state_d = WAIT;
      end
      WAIT: begin
        sa_resp_ready = 1'b1;
        if (sa_resp_valid) begin
          done_d  = done_q + 32'd1;
          advance = !tile_last;
          act_d   = col_wrap ? act_q + p_q : act_q;
          wgt_d   = col_wrap ? wgt_base_q : wgt_q + p_q;
          out_d   = out_q + Q;
          state_d = tile_last ? RESP : ISSUE;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (areset) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      inner_q    <= '0;
      p_q        <= '0;
      wgt_base_q <= '0;
      act_q      <= '0;
      wgt_q      <= '0;
      out_q      <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      inner_q    <= inner_d;
      p_q        <= p_d;
      wgt_base_q <= wgt_base_d;
      act_q      <= act_d;
      wgt_q      <= wgt_d;
      out_q      <= out_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb_matmul_tile_sequencer: directed and randomized checks against a loop-based tiling model
module tb_matmul_tile_sequencer;

  localparam int DIM = 8;
  localparam int EB  = 2;
  localparam logic [63:0] QB = 64'(DIM * DIM * EB);

  logic        clock = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_row_tiles = '0, cmd_col_tiles = '0;
  logic [19:0] cmd_inner_dimension = '0;
  logic [63:0] cmd_act_addr = '0, cmd_wgt_addr = '0, cmd_out_addr = '0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_tiles_done;
  logic        sa_cmd_valid, sa_cmd_ready = 1'b0;
  logic [19:0] sa_cmd_inner_dimension;
  logic [63:0] sa_cmd_act_addr, sa_cmd_wgt_addr, sa_cmd_out_addr;
  logic        sa_resp_valid = 1'b0, sa_resp_ready;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  matmul_tile_sequencer #(.SYSTOLIC_ARRAY_DIM(DIM), .DATA_WIDTH_BITS(EB * 8)) dut (
    .clock                  (clock),
    .areset                 (areset),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_row_tiles          (cmd_row_tiles),
    .cmd_col_tiles          (cmd_col_tiles),
    .cmd_inner_dimension    (cmd_inner_dimension),
    .cmd_act_addr           (cmd_act_addr),
    .cmd_wgt_addr           (cmd_wgt_addr),
    .cmd_out_addr           (cmd_out_addr),
    .resp_valid             (resp_valid),
    .resp_ready             (resp_ready),
    .resp_tiles_done        (resp_tiles_done),
    .sa_cmd_valid           (sa_cmd_valid),
    .sa_cmd_ready           (sa_cmd_ready),
    .sa_cmd_inner_dimension (sa_cmd_inner_dimension),
    .sa_cmd_act_addr        (sa_cmd_act_addr),
    .sa_cmd_wgt_addr        (sa_cmd_wgt_addr),
    .sa_cmd_out_addr        (sa_cmd_out_addr),
    .sa_resp_valid          (sa_resp_valid),
    .sa_resp_ready          (sa_resp_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_cmd(input int rows, input int cols, input int k,
                           input logic [63:0] a, input logic [63:0] w, input logic [63:0] o);
    cmd_row_tiles       = 16'(rows);
    cmd_col_tiles       = 16'(cols);
    cmd_inner_dimension = 20'(k);
    cmd_act_addr        = a;
    cmd_wgt_addr        = w;
    cmd_out_addr        = o;
  endtask

  task automatic run_cmd(input int min_stall, input int max_stall, output int n);
    logic [63:0] p, ea, ew, eo;
    int rows, cols, stall, lat;
    rows = int'(cmd_row_tiles);
    cols = int'(cmd_col_tiles);
    p = 64'(DIM * EB) * 64'(cmd_inner_dimension);
    n = (cmd_inner_dimension == 0) ? 0 : rows * cols;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    if (n == 0) begin
      chk("degenerate_no_sa_cmd", sa_cmd_valid, 0);
    end else begin
      for (int i = 0; i < rows; i++) begin
        for (int j = 0; j < cols; j++) begin
          ea = cmd_act_addr + 64'(i) * p;
          ew = cmd_wgt_addr + 64'(j) * p;
          eo = cmd_out_addr + (64'(i) * 64'(cols) + 64'(j)) * QB;
          stall = int'($urandom_range(max_stall, min_stall));
          for (int s = 0; s <= stall; s++) begin
            chk("sa_cmd_valid", sa_cmd_valid, 1);
            chk("sa_cmd_act", sa_cmd_act_addr, ea);
            chk("sa_cmd_wgt", sa_cmd_wgt_addr, ew);
            chk("sa_cmd_out", sa_cmd_out_addr, eo);
            chk("sa_cmd_inner", 64'(sa_cmd_inner_dimension), 64'(cmd_inner_dimension));
            chk("sa_resp_ready_in_issue", sa_resp_ready, 0);
            sa_resp_valid = (s == stall) ? 1'b0 : 1'($urandom_range(1, 0));
            sa_cmd_ready = (s == stall);
            step();
          end
          sa_cmd_ready = 1'b0;
          sa_resp_valid = 1'b0;
          lat = int'($urandom_range(4, 0));
          for (int s = 0; s <= lat; s++) begin
            chk("no_second_sa_cmd", sa_cmd_valid, 0);
            chk("sa_resp_ready_wait", sa_resp_ready, 1);
            chk("resp_valid_wait", resp_valid, 0);
            sa_resp_valid = (s == lat);
            step();
          end
          sa_resp_valid = 1'b0;
        end
      end
    end
    chk("resp_valid_done", resp_valid, 1);
    chk("tiles_done", 64'(resp_tiles_done), 64'(n));
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("sa_cmd_valid_resp", sa_cmd_valid, 0);
  endtask

  task automatic finish_resp(input int hold, input bit with_next, input int n);
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      cmd_valid = with_next;
      chk("cmd_ready_in_resp", cmd_ready, 0);
      chk("resp_valid_held", resp_valid, 1);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_valid_cleared", resp_valid, 0);
    chk("cmd_ready_after_resp", cmd_ready, 1);
    chk("tiles_done_held", 64'(resp_tiles_done), 64'(n));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_sa_cmd_valid"}, sa_cmd_valid, 0);
    chk({tag, "_sa_resp_ready"}, sa_resp_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_tiles_done"}, 64'(resp_tiles_done), 0);
    chk({tag, "_act"}, sa_cmd_act_addr, 0);
    chk({tag, "_wgt"}, sa_cmd_wgt_addr, 0);
    chk({tag, "_out"}, sa_cmd_out_addr, 0);
    chk({tag, "_inner"}, 64'(sa_cmd_inner_dimension), 0);
  endtask

  initial begin
    int n;
    int r, c, k;
    repeat (2) @(posedge clock);
    @(negedge clock);
    areset = 1'b0;
    chk_reset_state("reset");

    drive_cmd(1, 1, 8, 64'h4000, 64'h5000, 64'h6000);
    run_cmd(0, 0, n);
    finish_resp(0, 1'b0, n);

    drive_cmd(2, 3, 4, 64'h1000, 64'h2000, 64'h3000);
    run_cmd(0, 2, n);
    finish_resp(1, 1'b0, n);

    drive_cmd(3, 0, 16, 64'h7000, 64'h8000, 64'h9000);
    run_cmd(0, 0, n);
    finish_resp(0, 1'b0, n);

    drive_cmd(2, 2, 5, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FF80);
    run_cmd(5, 5, n);
    drive_cmd(1, 2, 3, 64'hA000, 64'hB000, 64'hC000);
    finish_resp(10, 1'b1, n);
    run_cmd(0, 1, n);
    finish_resp(0, 1'b0, n);

    drive_cmd(2, 2, 3, 64'h1_0000, 64'h2_0000, 64'h3_0000);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    sa_cmd_ready = 1'b1;
    step();
    sa_cmd_ready = 1'b0;
    chk("reached_wait", sa_resp_ready, 1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk_reset_state("midreset");
    step();
    chk("midreset_no_cmd", sa_cmd_valid, 0);
    drive_cmd(1, 1, 8, 64'hD000, 64'hE000, 64'hF000);
    run_cmd(0, 2, n);
    finish_resp(2, 1'b0, n);

    for (int t = 0; t < 10; t++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      k = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(1000, 1));
      drive_cmd(r, c, k, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      run_cmd(0, 3, n);
      finish_resp(int'($urandom_range(3, 0)), 1'b0, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
